// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - op codes, FSM state encodings and op helpers for the load/store unit
package mem_access_unit_pkg;

  // M-stage memory op codes
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  // Supported memory data-bus widths
  localparam int DATA_W_32 = 32;
  localparam int DATA_W_64 = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } mau_state_t;

  function automatic logic is_load(input logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP: is_load = 1'b1;
      default: is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    case (op)
      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: is_store = 1'b1;
      default: is_store = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// rtl/mem_access_unit_lane_align.sv - byte-lane placement, load extraction and alignment check
module mem_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8,
  localparam int OFF_W  = $clog2(STRB_W)
) (
  input  logic [7:0]        op,
  input  logic [OFF_W-1:0]  off,
  input  logic [31:0]       wdata,
  input  logic [7:0]        rd_op,
  input  logic [OFF_W-1:0]  rd_off,
  input  logic [DATA_W-1:0] rdata,
  output logic [STRB_W-1:0] strb,
  output logic [DATA_W-1:0] wdata_lane,
  output logic [31:0]       load_data,
  output logic              misaligned
);

  logic [OFF_W-1:0]  half_off;
  logic [OFF_W-1:0]  word_off;
  logic [DATA_W-1:0] rshift;

  assign half_off = off & ~OFF_W'(1);
  assign word_off = off & ~OFF_W'(3);
  assign rshift   = rdata >> {rd_off, 3'b000};

  // Store strobes and lane-shifted store data; loads drive nothing
  always_comb begin
    strb       = '0;
    wdata_lane = '0;
    case (op)
      EXE_SB_OP: begin
        strb       = STRB_W'(1) << off;
        wdata_lane = DATA_W'(wdata[7:0]) << {off, 3'b000};
      end
      EXE_SH_OP: begin
        strb       = STRB_W'(2'b11) << half_off;
        wdata_lane = DATA_W'(wdata[15:0]) << {half_off, 3'b000};
      end
      EXE_SW_OP: begin
        strb       = STRB_W'(4'hF) << word_off;
        wdata_lane = DATA_W'(wdata) << {word_off, 3'b000};
      end
      default: ;
    endcase
  end

  // Pick the addressed byte/half/word and sign- or zero-extend it
  always_comb begin
    load_data = rshift[31:0];
    case (rd_op)
      EXE_LB_OP:  load_data = {{24{rshift[7]}}, rshift[7:0]};
      EXE_LBU_OP: load_data = {24'b0, rshift[7:0]};
      EXE_LH_OP:  load_data = {{16{rshift[15]}}, rshift[15:0]};
      EXE_LHU_OP: load_data = {16'b0, rshift[15:0]};
      default: ;
    endcase
  end

  // Natural-alignment check for halfword and word accesses
  always_comb begin
    misaligned = 1'b0;
    case (op)
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: misaligned = off[0];
      EXE_LW_OP, EXE_SW_OP:             misaligned = |off[1:0];
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - M-stage load/store unit with memory handshake, stall and flush cancel
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 32,
  localparam int STRB_W = DATA_W / 8,
  localparam int OFF_W  = $clog2(STRB_W)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [7:0]        op_i,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [31:0]       rdata_o,
  output logic              adel_o,
  output logic              ades_o,
  output logic [ADDR_W-1:0] badvaddr_o,
  output logic              mem_req_o,
  output logic              mem_wr_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [STRB_W-1:0] mem_wstrb_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_addr_ok_i,
  input  logic              mem_data_ok_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  mau_state_t        state_q, state_d;
  logic              cancel_q, cancel_d;
  logic              load_en;
  logic [7:0]        op_q;
  logic [OFF_W-1:0]  off_q;
  logic [STRB_W-1:0] strb;
  logic [DATA_W-1:0] wdata_lane;
  logic [31:0]       load_data;
  logic              misal, is_ld, is_st, is_mem, start;

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .op         (op_i),
    .off        (addr_i[OFF_W-1:0]),
    .wdata      (wdata_i),
    .rd_op      (op_q),
    .rd_off     (off_q),
    .rdata      (mem_rdata_i),
    .strb       (strb),
    .wdata_lane (wdata_lane),
    .load_data  (load_data),
    .misaligned (misal)
  );

  assign is_ld      = is_load(op_i);
  assign is_st      = is_store(op_i);
  assign is_mem     = is_ld | is_st;
  assign adel_o     = req_i & is_ld & misal;
  assign ades_o     = req_i & is_st & misal;
  assign badvaddr_o = addr_i;
  assign start      = req_i & is_mem & ~misal & ~flush_i & (state_q == S_IDLE) & ~cancel_q;
  assign stall_o    = (start | (state_q == S_REQ) | (state_q == S_WAIT) |
                       (cancel_q & req_i & is_mem)) & ~flush_i;
  assign mem_req_o  = (state_q == S_REQ);

  // State and cancel registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
    end
  end

  // Next state, cancel tracking and load-result capture enable
  always_comb begin
    state_d  = state_q;
    cancel_d = cancel_q;
    load_en  = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_REQ;
      S_REQ: begin
        if (mem_addr_ok_i) begin
          if (mem_data_ok_i) begin
            state_d = flush_i ? S_IDLE : S_DONE;
            load_en = ~flush_i & ~mem_wr_o;
          end else begin
            state_d  = S_WAIT;
            cancel_d = flush_i;
          end
        end else if (flush_i) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (mem_data_ok_i) begin
          if (cancel_q | flush_i) begin
            state_d  = S_IDLE;
            cancel_d = 1'b0;
          end else begin
            state_d = S_DONE;
            load_en = ~mem_wr_o;
          end
        end else if (flush_i) begin
          cancel_d = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
    endcase
  end

  // Request capture at start and load result capture on data_ok
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q        <= '0;
      off_q       <= '0;
      mem_wr_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wstrb_o <= '0;
      mem_wdata_o <= '0;
      rdata_o     <= '0;
    end else begin
      if (start) begin
        op_q        <= op_i;
        off_q       <= addr_i[OFF_W-1:0];
        mem_wr_o    <= is_st;
        mem_addr_o  <= {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        mem_wstrb_o <= strb;
        mem_wdata_o <= wdata_lane;
      end
      if (load_en) rdata_o <= load_data;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit at 32- and 64-bit data width
module tb_mem_access_unit;

  localparam logic [7:0] OP_LB = 8'hE0, OP_LH = 8'hE1, OP_LW = 8'hE3, OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LHU = 8'hE5, OP_SB = 8'hE8, OP_SH = 8'hE9, OP_SW = 8'hEB;

  logic        clk = 0, resetn = 0;
  logic [7:0]  op = '0;
  logic        req32 = 0, req64 = 0, flush = 0;
  logic [31:0] addr = '0, wdata = '0;
  logic        aok = 0, dok = 0;
  logic [31:0] rd32 = '0;
  logic [63:0] rd64 = '0;

  logic        stall32, adel32, ades32, mreq32, mwr32;
  logic [31:0] res32, bad32, maddr32, mwdata32;
  logic [3:0]  mstrb32;
  logic        stall64, adel64, ades64, mreq64, mwr64;
  logic [31:0] res64, bad64, maddr64;
  logic [7:0]  mstrb64;
  logic [63:0] mwdata64;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32)) dut32 (
    .clk(clk), .resetn(resetn), .op_i(op), .req_i(req32), .addr_i(addr), .wdata_i(wdata),
    .flush_i(flush), .stall_o(stall32), .rdata_o(res32), .adel_o(adel32), .ades_o(ades32),
    .badvaddr_o(bad32), .mem_req_o(mreq32), .mem_wr_o(mwr32), .mem_addr_o(maddr32),
    .mem_wstrb_o(mstrb32), .mem_wdata_o(mwdata32), .mem_addr_ok_i(aok), .mem_data_ok_i(dok),
    .mem_rdata_i(rd32));

  mem_access_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .clk(clk), .resetn(resetn), .op_i(op), .req_i(req64), .addr_i(addr), .wdata_i(wdata),
    .flush_i(flush), .stall_o(stall64), .rdata_o(res64), .adel_o(adel64), .ades_o(ades64),
    .badvaddr_o(bad64), .mem_req_o(mreq64), .mem_wr_o(mwr64), .mem_addr_o(maddr64),
    .mem_wstrb_o(mstrb64), .mem_wdata_o(mwdata64), .mem_addr_ok_i(aok), .mem_data_ok_i(dok),
    .mem_rdata_i(rd64));

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  strb;
    logic [63:0] wdata;
  } req_t;

  req_t        req_q[$];
  logic [31:0] rsp_q[$];
  int          n_chk = 0, n_pass = 0;
  logic        sel64 = 0, mem_kill = 0, dok_seen = 0;
  int          aok_dly = 0, dok_dly = 1;
  int          rcnt = 0, dcnt = 0;
  bit          dpend = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Memory responder: addr_ok after aok_dly request cycles, data_ok dok_dly cycles after accept
  always @(posedge clk) begin
    #1;
    aok = 0;
    dok = 0;
    if (mem_kill) begin
      rcnt  = 0;
      dpend = 0;
    end else begin
      if (dpend) begin
        if (dcnt == 0) begin dok = 1; dpend = 0; end
        else dcnt--;
      end
      if (sel64 ? mreq64 : mreq32) begin
        if (rcnt == aok_dly) begin
          aok  = 1;
          rcnt = 0;
          if (dok_dly == 0) dok = 1;
          else begin dpend = 1; dcnt = dok_dly - 1; end
        end else rcnt++;
      end
    end
  end

  // Monitor: compare accepted requests and post-response rdata_o against the scoreboard
  always @(negedge clk) begin
    req_t e;
    if (dok_seen) begin
      if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
      else chk("rdata_o", sel64 ? res64 : res32, rsp_q.pop_front());
    end
    dok_seen = dok;
    if ((sel64 ? mreq64 : mreq32) && aok) begin
      if (req_q.size() == 0) chk("req_unexpected", 1, 0);
      else begin
        e = req_q.pop_front();
        chk("mem_wr", sel64 ? mwr64 : mwr32, e.wr);
        chk("mem_addr", sel64 ? maddr64 : maddr32, e.addr);
        chk("mem_wstrb", sel64 ? mstrb64 : {4'b0, mstrb32}, e.strb);
        if (e.wr) chk("mem_wdata", sel64 ? mwdata64 : {32'b0, mwdata32}, e.wdata);
      end
    end
  end

  task automatic run_op(input string name, input bit w64, input logic [7:0] o,
                        input logic [31:0] a, input logic [31:0] wd, input logic [63:0] rdv,
                        input int ad, input int dd, input logic [31:0] e_addr,
                        input logic [7:0] e_strb, input logic [63:0] e_wdata,
                        input logic [31:0] e_rsp, input int e_stall);
    req_t r;
    int   n = 0;
    sel64 = w64; aok_dly = ad; dok_dly = dd;
    if (w64) rd64 = rdv; else rd32 = rdv[31:0];
    r.wr = (o == OP_SB) || (o == OP_SH) || (o == OP_SW);
    r.addr = e_addr; r.strb = e_strb; r.wdata = e_wdata;
    req_q.push_back(r);
    rsp_q.push_back(e_rsp);
    op = o; addr = a; wdata = wd;
    if (w64) req64 = 1; else req32 = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((w64 ? stall64 : stall32) == 1'b0) break;
      n++;
    end
    chk({name, "_stall_cycles"}, 64'(n), 64'(e_stall));
    @(posedge clk); #1;
    req32 = 0; req64 = 0;
  endtask

  task automatic err_op(input string name, input bit w64, input logic [7:0] o,
                        input logic [31:0] a, input logic e_adel, input logic e_ades);
    logic any_req = 0, any_stall = 0;
    sel64 = w64; op = o; addr = a;
    if (w64) req64 = 1; else req32 = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk({name, "_adel"}, w64 ? adel64 : adel32, e_adel);
        chk({name, "_ades"}, w64 ? ades64 : ades32, e_ades);
        chk({name, "_badvaddr"}, w64 ? bad64 : bad32, a);
      end
      any_req   |= (w64 ? mreq64 : mreq32);
      any_stall |= (w64 ? stall64 : stall32);
    end
    chk({name, "_no_req"}, any_req, 0);
    chk({name, "_no_stall"}, any_stall, 0);
    @(posedge clk); #1;
    req32 = 0; req64 = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    req_t r;
    int   n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall32", stall32, 0);
    chk("rst_rdata32", res32, 0);
    chk("rst_mreq32", mreq32, 0);
    chk("rst_wstrb32", mstrb32, 0);
    chk("rst_mreq64", mreq64, 0);
    chk("rst_wdata64", mwdata64, 0);
    resetn = 1;
    @(posedge clk); #1;

    run_op("sb",  0, OP_SB,  32'h1003, 32'h12345678, 64'h0,        0, 2, 32'h1000, 8'h08, 64'h78000000, 32'h0,        4);
    run_op("lb",  0, OP_LB,  32'h1001, 32'h0,        64'h000080FF, 1, 0, 32'h1000, 8'h00, 64'h0,        32'hFFFFFF80, 3);
    run_op("lbu", 0, OP_LBU, 32'h1001, 32'h0,        64'h000080FF, 0, 1, 32'h1000, 8'h00, 64'h0,        32'h00000080, 3);
    run_op("lhu", 0, OP_LHU, 32'h1002, 32'h0,        64'hBEEF0000, 0, 0, 32'h1000, 8'h00, 64'h0,        32'h0000BEEF, 2);
    run_op("lh",  0, OP_LH,  32'h1000, 32'h0,        64'h00008001, 0, 1, 32'h1000, 8'h00, 64'h0,        32'hFFFF8001, 3);
    run_op("lw",  0, OP_LW,  32'h1004, 32'h0,        64'hCAFEF00D, 0, 1, 32'h1004, 8'h00, 64'h0,        32'hCAFEF00D, 3);
    run_op("sh",  0, OP_SH,  32'h1002, 32'h0000A5C3, 64'h0,        0, 1, 32'h1000, 8'h0C, 64'hA5C30000, 32'hCAFEF00D, 3);

    err_op("lw_misal", 0, OP_LW, 32'h1002, 1, 0);
    err_op("sh_misal", 0, OP_SH, 32'h1001, 0, 1);
    err_op("non_mem",  0, 8'h00, 32'h1000, 0, 0);

    run_op("lh64", 1, OP_LH, 32'h1006, 32'h0,        64'h8765432100000000, 0, 1, 32'h1000, 8'h00, 64'h0,                32'hFFFF8765, 3);
    run_op("sw64", 1, OP_SW, 32'h1004, 32'hAABBCCDD, 64'h0,                0, 1, 32'h1000, 8'hF0, 64'hAABBCCDD00000000, 32'hFFFF8765, 3);

    // flush while waiting for read data: response discarded, next load held until idle
    sel64 = 0; aok_dly = 0; dok_dly = 4; rd32 = 32'hFFFFFFFF;
    r.wr = 0; r.addr = 32'h1008; r.strb = 8'h00; r.wdata = 64'h0;
    req_q.push_back(r);
    rsp_q.push_back(32'hCAFEF00D);
    op = OP_LW; addr = 32'h1008; req32 = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1; req32 = 0;
    @(negedge clk);
    chk("flush_stall", stall32, 0);
    @(posedge clk); #1;
    flush = 0; req32 = 1; addr = 32'h100C;
    @(negedge clk);
    chk("cancel_stall", stall32, 1);
    chk("cancel_no_req", mreq32, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("cancel_stall_dok", stall32, 1);
    @(posedge clk); #1;
    rd32 = 32'h13579BDF;
    r.addr = 32'h100C;
    req_q.push_back(r);
    rsp_q.push_back(32'h13579BDF);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (stall32 == 1'b0) break;
      n++;
    end
    chk("reissue_stall_cycles", 64'(n), 6);
    @(posedge clk); #1;
    req32 = 0;

    // asynchronous reset in the middle of an outstanding load
    sel64 = 0; aok_dly = 0; dok_dly = 10; rd32 = 32'h55555555;
    r.addr = 32'h1010;
    req_q.push_back(r);
    op = OP_LW; addr = 32'h1010; req32 = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    resetn = 0; mem_kill = 1; req32 = 0;
    #1;
    chk("async_rst_stall", stall32, 0);
    chk("async_rst_rdata", res32, 0);
    chk("async_rst_mreq", mreq32, 0);
    @(posedge clk); #2;
    resetn = 1; mem_kill = 0;
    @(posedge clk); #1;
    run_op("sw_after_rst", 0, OP_SW, 32'h1014, 32'h0BADF00D, 64'h0, 0, 1, 32'h1014, 8'h0F, 64'h0BADF00D, 32'h0, 3);

    repeat (3) @(posedge clk);
    #1;
    chk("req_q_drained", 64'(req_q.size()), 0);
    chk("rsp_q_drained", 64'(rsp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
